// File: rtl/b2_dec_hold.sv
// Registered 4-to-16 one-hot decoder with valid/ready capture and a programmable hold time.
// Refused offers (busy or disabled) are counted in a saturating 8-bit counter.
module b2_dec_hold #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  binary_in,
    output logic [15:0] binary_out,
    output logic        out_valid,
    output logic [7:0]  drop_cnt
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    // Counter loads HOLD_CYCLES-1 so the word is visible for exactly HOLD_CYCLES periods.
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    logic [0:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] out_q, out_d;
    logic        valid_q, valid_d;
    logic [7:0]  drop_q, drop_d;
    logic        accept;
    logic        refuse;

    assign in_ready = enable && (state_q == IDLE);
    assign accept   = in_valid && in_ready;
    assign refuse   = in_valid && !in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    out_d   = 16'd1 << binary_in;
                    valid_d = 1'b1;
                    cnt_d   = HOLD_LOAD;
                    state_d = HOLD;
                end else begin
                    out_d   = 16'd0;
                    valid_d = 1'b0;
                end
            end
            HOLD: begin
                // Dropping enable aborts the hold immediately; otherwise count down to 0.
                if (!enable || (cnt_q == 8'd0)) begin
                    out_d   = 16'd0;
                    valid_d = 1'b0;
                    cnt_d   = 8'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                out_d   = 16'd0;
                valid_d = 1'b0;
                cnt_d   = 8'd0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        drop_d = drop_q;
        if (refuse && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            out_q   <= 16'd0;
            valid_q <= 1'b0;
            drop_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    assign binary_out = out_q;
    assign out_valid  = valid_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_b2_dec_hold.sv
// Directed self-checking bench for b2_dec_hold: one instance with HOLD_CYCLES=4,
// a second with HOLD_CYCLES=1 for the single-cycle hold case.
module tb_b2_dec_hold;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  binary_in;
    logic [15:0] binary_out;
    logic        out_valid;
    logic [7:0]  drop_cnt;

    logic        enable1;
    logic        in_valid1;
    logic        in_ready1;
    logic [3:0]  binary_in1;
    logic [15:0] binary_out1;
    logic        out_valid1;
    logic [7:0]  drop_cnt1;

    int compared;
    int mismatched;

    b2_dec_hold #(.HOLD_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .binary_in  (binary_in),
        .binary_out (binary_out),
        .out_valid  (out_valid),
        .drop_cnt   (drop_cnt)
    );

    b2_dec_hold #(.HOLD_CYCLES(1)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable1),
        .in_valid   (in_valid1),
        .in_ready   (in_ready1),
        .binary_in  (binary_in1),
        .binary_out (binary_out1),
        .out_valid  (out_valid1),
        .drop_cnt   (drop_cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle 1ns past it so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        enable     = 1'b1;
        in_valid   = 1'b0;
        binary_in  = 4'd0;
        enable1    = 1'b1;
        in_valid1  = 1'b0;
        binary_in1 = 4'd0;
        #12;
        compared++;
        if (binary_out !== 16'h0000 || out_valid !== 1'b0 || drop_cnt !== 8'd0 || in_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset: out=%h valid=%b drop=%0d ready=%b, want 0000/0/0/1",
                     binary_out, out_valid, drop_cnt, in_ready);
        end
        compared++;
        if (binary_out1 !== 16'h0000 || out_valid1 !== 1'b0 || drop_cnt1 !== 8'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_h1: out=%h valid=%b drop=%0d, want 0000/0/0",
                     binary_out1, out_valid1, drop_cnt1);
        end
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_sweep();
        logic [15:0] exp;
        for (int code = 0; code < 16; code++) begin
            exp = 16'h0001;
            exp = exp << code;
            compared++;
            if (in_ready !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL sweep_ready code %0d: ready=%b, want 1", code, in_ready);
            end
            in_valid  = 1'b1;
            binary_in = 4'(code);
            step();
            in_valid  = 1'b0;
            binary_in = 4'(15 - code);
            for (int c = 0; c < 4; c++) begin
                compared++;
                if (binary_out !== exp || out_valid !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL sweep_hold code %0d cyc %0d: out=%h valid=%b, want %h/1",
                             code, c, binary_out, out_valid, exp);
                end
                if (c < 3) step();
            end
            step();
            compared++;
            if (binary_out !== 16'h0000 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL sweep_gap code %0d: out=%h valid=%b ready=%b, want 0000/0/1",
                         code, binary_out, out_valid, in_ready);
            end
        end
        compared++;
        if (drop_cnt !== 8'd0) begin
            mismatched++;
            $display("[TB] FAIL sweep_drop: drop=%0d, want 0", drop_cnt);
        end
    endtask

    task automatic test_busy_refusal();
        in_valid  = 1'b1;
        binary_in = 4'd5;
        step();
        binary_in = 4'd9;
        for (int c = 0; c < 4; c++) begin
            compared++;
            if (binary_out !== 16'h0020 || out_valid !== 1'b1 || in_ready !== 1'b0 || drop_cnt !== 8'(c)) begin
                mismatched++;
                $display("[TB] FAIL busy_hold cyc %0d: out=%h valid=%b ready=%b drop=%0d, want 0020/1/0/%0d",
                         c, binary_out, out_valid, in_ready, drop_cnt, c);
            end
            step();
        end
        compared++;
        if (binary_out !== 16'h0000 || out_valid !== 1'b0 || drop_cnt !== 8'd4 || in_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL busy_gap: out=%h valid=%b drop=%0d ready=%b, want 0000/0/4/1",
                     binary_out, out_valid, drop_cnt, in_ready);
        end
        step();
        in_valid = 1'b0;
        compared++;
        if (binary_out !== 16'h0200 || out_valid !== 1'b1 || drop_cnt !== 8'd4) begin
            mismatched++;
            $display("[TB] FAIL busy_accept9: out=%h valid=%b drop=%0d, want 0200/1/4",
                     binary_out, out_valid, drop_cnt);
        end
        for (int c = 0; c < 4; c++) step();
        compared++;
        if (binary_out !== 16'h0000 || in_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL busy_end: out=%h ready=%b, want 0000/1", binary_out, in_ready);
        end
    endtask

    task automatic test_abort();
        in_valid  = 1'b1;
        binary_in = 4'd12;
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            compared++;
            if (binary_out !== 16'h1000 || out_valid !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL abort_hold cyc %0d: out=%h valid=%b, want 1000/1", c, binary_out, out_valid);
            end
            if (c == 0) step();
        end
        enable = 1'b0;
        step();
        compared++;
        if (binary_out !== 16'h0000 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL abort_clear: out=%h valid=%b ready=%b, want 0000/0/0",
                     binary_out, out_valid, in_ready);
        end
        step();
        step();
        compared++;
        if (in_ready !== 1'b0 || binary_out !== 16'h0000 || drop_cnt !== 8'd4) begin
            mismatched++;
            $display("[TB] FAIL abort_idle: ready=%b out=%h drop=%0d, want 0/0000/4",
                     in_ready, binary_out, drop_cnt);
        end
        enable = 1'b1;
        #1;
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL abort_ready_back: ready=%b, want 1", in_ready);
        end
        in_valid  = 1'b1;
        binary_in = 4'd2;
        step();
        in_valid = 1'b0;
        compared++;
        if (binary_out !== 16'h0004 || out_valid !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL abort_next: out=%h valid=%b, want 0004/1", binary_out, out_valid);
        end
        for (int c = 0; c < 4; c++) step();
    endtask

    task automatic test_back_to_back();
        in_valid1  = 1'b1;
        binary_in1 = 4'd3;
        step();
        binary_in1 = 4'd7;
        compared++;
        if (binary_out1 !== 16'h0008 || out_valid1 !== 1'b1 || in_ready1 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL b2b_first: out=%h valid=%b ready=%b, want 0008/1/0",
                     binary_out1, out_valid1, in_ready1);
        end
        step();
        compared++;
        if (binary_out1 !== 16'h0000 || out_valid1 !== 1'b0 || drop_cnt1 !== 8'd1) begin
            mismatched++;
            $display("[TB] FAIL b2b_gap: out=%h valid=%b drop=%0d, want 0000/0/1",
                     binary_out1, out_valid1, drop_cnt1);
        end
        step();
        in_valid1 = 1'b0;
        compared++;
        if (binary_out1 !== 16'h0080 || out_valid1 !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL b2b_second: out=%h valid=%b, want 0080/1", binary_out1, out_valid1);
        end
        step();
        compared++;
        if (binary_out1 !== 16'h0000 || out_valid1 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL b2b_end: out=%h valid=%b, want 0000/0", binary_out1, out_valid1);
        end
    endtask

    task automatic test_saturation();
        int bad_out;
        bad_out  = 0;
        enable   = 1'b0;
        in_valid = 1'b1;
        for (int e = 0; e < 300; e++) begin
            step();
            if (binary_out !== 16'h0000 || out_valid !== 1'b0) bad_out++;
        end
        compared++;
        if (bad_out != 0) begin
            mismatched++;
            $display("[TB] FAIL sat_out: %0d cycles with nonzero output, want 0", bad_out);
        end
        compared++;
        if (drop_cnt !== 8'd255) begin
            mismatched++;
            $display("[TB] FAIL sat_drop: drop=%0d, want 255", drop_cnt);
        end
        in_valid = 1'b0;
        enable   = 1'b1;
    endtask

    task automatic test_async_reset();
        in_valid  = 1'b1;
        binary_in = 4'd6;
        step();
        in_valid = 1'b0;
        compared++;
        if (binary_out !== 16'h0040 || drop_cnt !== 8'd255) begin
            mismatched++;
            $display("[TB] FAIL areset_pre: out=%h drop=%0d, want 0040/255", binary_out, drop_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        compared++;
        if (binary_out !== 16'h0000 || out_valid !== 1'b0 || drop_cnt !== 8'd0) begin
            mismatched++;
            $display("[TB] FAIL areset_clear: out=%h valid=%b drop=%0d, want 0000/0/0",
                     binary_out, out_valid, drop_cnt);
        end
        #2;
        rst_n = 1'b1;
        in_valid  = 1'b1;
        binary_in = 4'd15;
        step();
        in_valid = 1'b0;
        compared++;
        if (binary_out !== 16'h8000 || out_valid !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL areset_accept15: out=%h valid=%b, want 8000/1", binary_out, out_valid);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_sweep();
        test_busy_refusal();
        test_abort();
        test_back_to_back();
        test_saturation();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
